// File: rtl/fde_sequencer.sv
// Instruction-cycle sequencer: walks NUM_PHASES one-hot phases per instruction,
// inserts per-phase wait states, honours stall/step/enable, halts at instruction
// boundaries and counts retired instructions.
module fde_sequencer #(
   parameter  int unsigned NUM_PHASES = 3,
   parameter  int unsigned WAIT_W     = 4,
   parameter  int unsigned CNT_W      = 16,
   localparam int unsigned PHASE_W    = $clog2(NUM_PHASES)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         stall,
   input  logic                         step_mode,
   input  logic                         step,
   input  logic                         halt_req,
   input  logic                         resume,
   input  logic [NUM_PHASES*WAIT_W-1:0] wait_cycles,
   output logic [NUM_PHASES-1:0]        phase_onehot,
   output logic [PHASE_W-1:0]           phase_idx,
   output logic                         phase_last,
   output logic                         cycle_done,
   output logic                         idle,
   output logic                         halted,
   output logic [CNT_W-1:0]             instr_count
);

   localparam logic [PHASE_W-1:0] LastPh = PHASE_W'(NUM_PHASES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

   state_e                  state_q, state_d;
   logic [PHASE_W-1:0]      ph_q, ph_d;
   logic [WAIT_W-1:0]       wc_q, wc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_PHASES-1:0]   onehot_q, onehot_d;
   logic [PHASE_W-1:0]      idx_q, idx_d;
   logic                    idle_q, idle_d;
   logic                    halted_q, halted_d;

   logic [WAIT_W-1:0]       cur_wait;
   logic                    run;
   logic                    adv;
   logic                    at_last_ph;
   logic                    last_cyc;

   // Select the wait-state budget of the active phase.
   always_comb begin
      cur_wait = '0;
      for (int p = 0; p < NUM_PHASES; p++) begin
         if (ph_q == PHASE_W'(p)) begin
            cur_wait = wait_cycles[p*WAIT_W +: WAIT_W];
         end
      end
   end

   // Live phase-end compare: shrinking the budget mid-phase ends it at once.
   always_comb begin
      run        = (state_q == StRun);
      adv        = enable & ~stall & (~step_mode | step);
      at_last_ph = (ph_q == LastPh);
      last_cyc   = run & (wc_q >= cur_wait);
      phase_last = last_cyc;
      cycle_done = ~rst & run & adv & last_cyc & at_last_ph;
   end

   // Next state, phase, wait counter, retire counter and registered outputs.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      wc_d    = wc_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StRun;
               ph_d    = '0;
               wc_d    = '0;
            end
         end
         StRun: begin
            if (adv) begin
               if (!last_cyc) begin
                  wc_d = wc_q + WAIT_W'(1);
               end else if (!at_last_ph) begin
                  ph_d = ph_q + PHASE_W'(1);
                  wc_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  ph_d  = '0;
                  wc_d  = '0;
                  if (halt_req) begin
                     state_d = StHalted;
                  end
               end
            end
         end
         StHalted: begin
            // resume wins over a concurrent halt_req
            if (enable && resume) begin
               state_d = StRun;
               ph_d    = '0;
               wc_d    = '0;
            end
         end
         default: begin
            state_d = StIdle;
            ph_d    = '0;
            wc_d    = '0;
         end
      endcase

      onehot_d = '0;
      for (int p = 0; p < NUM_PHASES; p++) begin
         onehot_d[p] = (state_d == StRun) && (ph_d == PHASE_W'(p));
      end
      idx_d    = (state_d == StRun) ? ph_d : '0;
      idle_d   = (state_d == StIdle);
      halted_d = (state_d == StHalted);
   end

   // State register; rst dominates every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ph_q     <= '0;
         wc_q     <= '0;
         cnt_q    <= '0;
         onehot_q <= '0;
         idx_q    <= '0;
         idle_q   <= 1'b1;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         wc_q     <= wc_d;
         cnt_q    <= cnt_d;
         onehot_q <= onehot_d;
         idx_q    <= idx_d;
         idle_q   <= idle_d;
         halted_q <= halted_d;
      end
   end

   assign phase_onehot = onehot_q;
   assign phase_idx    = idx_q;
   assign idle         = idle_q;
   assign halted       = halted_q;
   assign instr_count  = cnt_q;

endmodule

// File: tb/tb_fde_sequencer.sv
// Scoreboard bench for fde_sequencer: the driver applies directed vectors at
// the falling edge and queues the hand-computed response; a monitor pops and
// compares shortly after.
module tb_fde_sequencer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: 3 phases, 4-bit waits, 16-bit counter.
   logic        rst = 1'b1, enable = 1'b0, stall = 1'b0, step_mode = 1'b0;
   logic        step = 1'b0, halt_req = 1'b0, resume = 1'b0;
   logic [11:0] wait_cycles = '0;
   logic [2:0]  phase_onehot;
   logic [1:0]  phase_idx;
   logic        phase_last, cycle_done, idle, halted;
   logic [15:0] instr_count;

   // Wrap instance: 2 phases, 4-bit counter.
   logic        rst2 = 1'b1, en2 = 1'b0;
   logic [7:0]  wait2 = '0;
   logic [1:0]  oh2;
   logic        idx2, last2, done2, idle2, halted2;
   logic [3:0]  cnt2;

   fde_sequencer #(.NUM_PHASES(3), .WAIT_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .stall(stall), .step_mode(step_mode),
      .step(step), .halt_req(halt_req), .resume(resume), .wait_cycles(wait_cycles),
      .phase_onehot(phase_onehot), .phase_idx(phase_idx), .phase_last(phase_last),
      .cycle_done(cycle_done), .idle(idle), .halted(halted), .instr_count(instr_count)
   );

   fde_sequencer #(.NUM_PHASES(2), .WAIT_W(4), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst2), .enable(en2), .stall(1'b0), .step_mode(1'b0),
      .step(1'b0), .halt_req(1'b0), .resume(1'b0), .wait_cycles(wait2),
      .phase_onehot(oh2), .phase_idx(idx2), .phase_last(last2),
      .cycle_done(done2), .idle(idle2), .halted(halted2), .instr_count(cnt2)
   );

   typedef struct {
      bit          sel;
      int          id;
      logic [7:0]  oh;
      logic [2:0]  idx;
      logic        last, done, idl, hlt;
      logic [15:0] cnt;
   } exp_t;

   exp_t        q[$];
   int          n_vec = 0;
   int          miscompares = 0;
   int          vec_id = 0;
   logic        rst_set = 1'b0;
   logic [11:0] wait_set = '0;

   task automatic chk(input string nm, input int id, input logic [15:0] act,
                      input logic [15:0] exp_v);
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, exp_v);
      end
   endtask

   function automatic exp_t mk(input bit sel, input int ph, input logic last,
                               input logic done, input logic idl, input logic hlt,
                               input int cnt);
      exp_t e;
      e.sel  = sel;
      e.id   = vec_id;
      e.oh   = (ph < 0) ? 8'd0 : (8'd1 << ph);
      e.idx  = (ph < 0) ? 3'd0 : 3'(ph);
      e.last = last;
      e.done = done;
      e.idl  = idl;
      e.hlt  = hlt;
      e.cnt  = 16'(cnt);
      return e;
   endfunction

   // One cycle on the main instance; ph = -1 means no active phase.
   task automatic cyc(input logic en, input logic st, input logic sm, input logic sp,
                      input logic hr, input logic rsm, input int ph, input logic last,
                      input logic done, input logic idl, input logic hlt, input int cnt);
      @(negedge clk);
      rst         = rst_set;
      wait_cycles = wait_set;
      enable      = en;
      stall       = st;
      step_mode   = sm;
      step        = sp;
      halt_req    = hr;
      resume      = rsm;
      q.push_back(mk(1'b0, ph, last, done, idl, hlt, cnt));
      vec_id++;
   endtask

   // One cycle on the wrap instance.
   task automatic cyc2(input logic en, input int ph, input logic last, input logic done,
                       input logic idl, input int cnt);
      @(negedge clk);
      rst2 = 1'b0;
      en2  = en;
      q.push_back(mk(1'b1, ph, last, done, idl, 1'b0, cnt));
      vec_id++;
   endtask

   // Monitor: compare the queued response against the selected instance.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (!e.sel) begin
               chk("onehot", e.id, 16'(phase_onehot), 16'(e.oh));
               chk("idx",    e.id, 16'(phase_idx),    16'(e.idx));
               chk("last",   e.id, 16'(phase_last),   16'(e.last));
               chk("done",   e.id, 16'(cycle_done),   16'(e.done));
               chk("idle",   e.id, 16'(idle),         16'(e.idl));
               chk("halted", e.id, 16'(halted),       16'(e.hlt));
               chk("count",  e.id, instr_count,       e.cnt);
            end else begin
               chk("onehot2", e.id, 16'(oh2),     16'(e.oh));
               chk("idx2",    e.id, 16'(idx2),    16'(e.idx));
               chk("last2",   e.id, 16'(last2),   16'(e.last));
               chk("done2",   e.id, 16'(done2),   16'(e.done));
               chk("idle2",   e.id, 16'(idle2),   16'(e.idl));
               chk("halted2", e.id, 16'(halted2), 16'(e.hlt));
               chk("count2",  e.id, 16'(cnt2),    e.cnt);
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      int t2_ph[6]   = '{0, 0, 1, 2, 2, 2};
      bit t2_last[6] = '{0, 1, 1, 0, 0, 1};
      int ph;

      repeat (3) @(negedge clk);

      // 1: reset state, then free-running with zero waits
      cyc(1, 0, 0, 0, 0, 0, -1, 0, 0, 1, 0, 0);
      for (int r = 0; r < 12; r++) begin
         cyc(1, 0, 0, 0, 0, 0, r % 3, 1, (r % 3) == 2, 0, 0, r / 3);
      end

      // 2: fetch=1, decode=0, execute=2 extra cycles
      wait_set = 12'h201;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 6; j++) begin
            cyc(1, 0, 0, 0, 0, 0, t2_ph[j], t2_last[j], j == 5, 0, 0, 4 + i);
         end
      end
      wait_set = 12'h000;

      // 3: single-step, pulse every 4th cycle, pulse at k=7 stalled
      for (int k = 0; k < 16; k++) begin
         ph = (k < 4) ? 0 : (k < 12) ? 1 : 2;
         cyc(1, k == 7, 1, (k % 4) == 3, 0, 0, ph, 1, k == 15, 0, 0, 6);
      end

      // 4: halt only at the instruction boundary
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7);
      cyc(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 7);
      cyc(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 7);
      cyc(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 8);
      cyc(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 8);
      cyc(1, 0, 0, 0, 1, 0, 2, 1, 1, 0, 0, 8);
      cyc(1, 0, 0, 0, 1, 0, -1, 0, 0, 0, 1, 9);
      cyc(0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 1, 9);
      cyc(1, 1, 1, 1, 0, 0, -1, 0, 0, 0, 1, 9);
      cyc(1, 0, 0, 0, 1, 1, -1, 0, 0, 0, 1, 9);
      cyc(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 9);

      // 5: execute wait 2, freeze at wc=1, then reset mid-execute
      wait_set = 12'h200;
      cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 9);
      cyc(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 9);
      for (int k = 0; k < 5; k++) begin
         cyc(0, k[0], 0, 1, 1, 1, 2, 0, 0, 0, 0, 9);
      end
      rst_set = 1'b1;
      cyc(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 9);
      rst_set = 1'b0;
      wait_set = 12'h000;
      cyc(0, 0, 0, 0, 0, 0, -1, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, -1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, -1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // 6: two-phase instance, 4-bit counter wraps 15 -> 0
      cyc2(1, -1, 0, 0, 1, 0);
      for (int r = 0; r < 34; r++) begin
         cyc2(1, r % 2, 1, (r % 2) == 1, 0, (r / 2) % 16);
      end

      #5;
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #5;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end

endmodule
